// File: rtl/ipv4_rx_handler.sv
// IPv4 receive stage: validates the header, strips header and options, forwards the TCP segment
// and publishes per-packet metadata. Define IPV4_HDR_CHECKSUM_EN to verify the header checksum.
module ipv4_rx_handler #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter logic [31:0] LOCAL_IP   = 32'hC0A8_0164
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  meta_valid,
  input  logic                  meta_ready,
  output logic [31:0]           meta_src_ip,
  output logic [31:0]           meta_dst_ip,
  output logic [15:0]           meta_tcp_len,
  output logic                  meta_err,
  output logic                  drop_pulse
);

  typedef enum logic [1:0] {S_HDR, S_FWD, S_DRAIN, S_META} state_t;

  state_t      state, state_nxt;
  logic        active;
  logic [15:0] byte_cnt, pay_cnt;
  logic [7:0]  ver_ihl, protocol;
  logic [15:0] total_len;
  logic [13:0] frag;
  logic [31:0] src_ip, dst_ip, dst_cur;
  logic [15:0] tcp_len, ihl4, hdr_end;
  logic        drop_flag, err_flag;
  logic        s_fire, hdr_last, pay_last, csum_ok, checks_ok;

  assign s_fire   = s_axis_tvalid && s_axis_tready;
  assign ihl4     = {10'd0, ver_ihl[3:0], 2'b00};
  // A malformed IHL below 5 still consumes the fixed 20-byte header before being rejected.
  assign hdr_end  = (ver_ihl[3:0] < 4'd5) ? 16'd19 : ihl4 - 16'd1;
  assign hdr_last = (byte_cnt == hdr_end);
  assign pay_last = (pay_cnt == tcp_len - 16'd1);
  assign dst_cur  = (byte_cnt >= 16'd16 && byte_cnt <= 16'd19) ?
                    {dst_ip[23:0], s_axis_tdata} : dst_ip;

`ifdef IPV4_HDR_CHECKSUM_EN
  logic [7:0]  csum_hi;
  logic [15:0] csum_acc, csum_fold;
  logic [16:0] csum_sum;

  assign csum_sum  = {1'b0, csum_acc} + {1'b0, csum_hi, s_axis_tdata};
  assign csum_fold = csum_sum[15:0] + {15'd0, csum_sum[16]};
  assign csum_ok   = (csum_fold == 16'hFFFF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum_hi  <= '0;
      csum_acc <= '0;
    end else if (state == S_HDR && s_fire) begin
      if (s_axis_tlast || hdr_last) csum_acc <= '0;
      else if (byte_cnt[0])         csum_acc <= csum_fold;
      else                          csum_hi  <= s_axis_tdata;
    end
  end
`else
  assign csum_ok = 1'b1;
`endif

  assign checks_ok = (ver_ihl[7:4] == 4'd4) && (ver_ihl[3:0] >= 4'd5) && (protocol == 8'd6) &&
                     (dst_cur == LOCAL_IP) && (frag == 14'd0) &&
                     (total_len >= ihl4 + 16'd20) && csum_ok;

  assign s_axis_tready = active && ((state == S_HDR) || (state == S_DRAIN) ||
                         ((state == S_FWD) && (!m_axis_tvalid || m_axis_tready)));
  assign meta_valid    = (state == S_META);
  assign meta_src_ip   = src_ip;
  assign meta_dst_ip   = dst_ip;
  assign meta_tcp_len  = tcp_len;
  assign meta_err      = err_flag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_HDR;
      active <= 1'b0;
    end else begin
      state  <= state_nxt;
      active <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_HDR: if (s_fire) begin
        if (s_axis_tlast)  state_nxt = S_HDR;
        else if (hdr_last) state_nxt = checks_ok ? S_FWD : S_DRAIN;
      end
      S_FWD: if (s_fire) begin
        if (pay_last)          state_nxt = s_axis_tlast ? S_META : S_DRAIN;
        else if (s_axis_tlast) state_nxt = S_META;
      end
      S_DRAIN: if (s_fire && s_axis_tlast) state_nxt = drop_flag ? S_HDR : S_META;
      S_META:  if (meta_ready) state_nxt = S_HDR;
      default: state_nxt = S_HDR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt      <= '0;
      pay_cnt       <= '0;
      ver_ihl       <= '0;
      protocol      <= '0;
      total_len     <= '0;
      frag          <= '0;
      src_ip        <= '0;
      dst_ip        <= '0;
      tcp_len       <= '0;
      drop_flag     <= 1'b0;
      err_flag      <= 1'b0;
      drop_pulse    <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
    end else begin
      drop_pulse <= 1'b0;
      if (state == S_FWD && s_fire) begin
        m_axis_tdata  <= s_axis_tdata;
        m_axis_tvalid <= 1'b1;
        m_axis_tlast  <= pay_last || s_axis_tlast;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end

      case (state)
        S_HDR: if (s_fire) begin
          byte_cnt <= byte_cnt + 16'd1;
          dst_ip   <= dst_cur;
          case (byte_cnt)
            16'd0:  ver_ihl         <= s_axis_tdata;
            16'd2:  total_len[15:8] <= s_axis_tdata;
            16'd3:  total_len[7:0]  <= s_axis_tdata;
            16'd6:  frag[13:8]      <= s_axis_tdata[5:0];
            16'd7:  frag[7:0]       <= s_axis_tdata;
            16'd9:  protocol        <= s_axis_tdata;
            16'd12, 16'd13, 16'd14, 16'd15: src_ip <= {src_ip[23:0], s_axis_tdata};
            default: ;
          endcase
          if (s_axis_tlast) begin
            byte_cnt   <= '0;
            drop_pulse <= 1'b1;
          end else if (hdr_last) begin
            byte_cnt  <= '0;
            pay_cnt   <= '0;
            drop_flag <= !checks_ok;
            tcp_len   <= checks_ok ? total_len - ihl4 : '0;
          end
        end
        S_FWD: if (s_fire) begin
          pay_cnt <= pay_cnt + 16'd1;
          if (s_axis_tlast && !pay_last) err_flag <= 1'b1;
        end
        S_DRAIN: if (s_fire && s_axis_tlast && drop_flag) begin
          drop_pulse <= 1'b1;
          drop_flag  <= 1'b0;
        end
        S_META: if (meta_ready) begin
          pay_cnt   <= '0;
          err_flag  <= 1'b0;
          drop_flag <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ipv4_rx_handler.sv
// Randomized bench for ipv4_rx_handler against a packet-level reference model.
module tb_ipv4_rx_handler;
  localparam logic [31:0] LOCAL_IP = 32'hC0A8_0164;

  logic        clk;
  logic        rst_n;
  logic [7:0]  s_tdata;
  logic        s_tvalid, s_tready, s_tlast;
  logic [7:0]  m_tdata;
  logic        m_tvalid, m_tready, m_tlast;
  logic        meta_valid, meta_ready;
  logic [31:0] meta_src_ip, meta_dst_ip;
  logic [15:0] meta_tcp_len;
  logic        meta_err, drop_pulse;

  ipv4_rx_handler #(.DATA_WIDTH(8), .LOCAL_IP(LOCAL_IP)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tlast(m_tlast),
    .meta_valid(meta_valid), .meta_ready(meta_ready), .meta_src_ip(meta_src_ip),
    .meta_dst_ip(meta_dst_ip), .meta_tcp_len(meta_tcp_len), .meta_err(meta_err),
    .drop_pulse(drop_pulse)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rmode = 0;
  int last_acc_cyc = 0;
  int first_meta_cyc = 0;
  int drop_cnt = 0;
  int drop_cyc = 0;
  bit meta_seen = 0;
  logic [31:0] cap_src, cap_dst;
  logic [15:0] cap_len;
  logic        cap_err;
  logic [8:0]  got_q[$];
  logic [8:0]  exp_q[$];
  logic [7:0]  pkt[$];
  bit          exp_drop, exp_err;
  logic [31:0] exp_src, exp_dst;
  int          exp_len;
  logic        stall;
  logic [8:0]  held;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Downstream ready pattern: always ready, alternating, or random.
  initial begin
    m_tready = 1'b1;
    forever begin
      @(negedge clk);
      case (rmode)
        0:       m_tready = 1'b1;
        1:       m_tready = !m_tready;
        default: m_tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Observer: output transfers, hold-while-stalled, metadata stability, drop pulses.
  initial begin
    stall = 1'b0;
    held  = '0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        stall = 1'b0;
        continue;
      end
      if (stall) begin
        check("m_hold_valid", 32'(m_tvalid), 32'd1);
        check("m_hold_data", 32'({m_tlast, m_tdata}), 32'(held));
      end
      stall = m_tvalid && !m_tready;
      held  = {m_tlast, m_tdata};
      if (m_tvalid && m_tready) got_q.push_back({m_tlast, m_tdata});
      if (meta_valid) begin
        if (!meta_seen) begin
          meta_seen = 1'b1;
          first_meta_cyc = cyc;
          cap_src = meta_src_ip; cap_dst = meta_dst_ip;
          cap_len = meta_tcp_len; cap_err = meta_err;
        end else begin
          check("meta_hold_len", 32'(meta_tcp_len), 32'(cap_len));
          check("meta_hold_src", meta_src_ip, cap_src);
          check("meta_hold_err", 32'(meta_err), 32'(cap_err));
        end
      end
      if (drop_pulse) begin
        drop_cnt++;
        drop_cyc = cyc;
      end
    end
  end

  task automatic send_byte(input logic [7:0] d, input logic l);
    int unsigned guard;
    guard = 0;
    s_tdata = d; s_tvalid = 1'b1; s_tlast = l;
    #1;
    while (!s_tready && guard < 60) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (guard >= 60) check("s_tready_timeout", 32'd0, 32'd1);
    @(negedge clk);
    last_acc_cyc = cyc;
    s_tvalid = 1'b0; s_tlast = 1'b0;
  endtask

  task automatic build_pkt(input int ver, input int ihl, input int tl, input int proto,
                           input logic [31:0] dst, input logic [15:0] frag, input int n,
                           input bit corrupt);
    int hl;
    int unsigned s;
    logic [15:0] cs;
    logic [31:0] src;
    hl  = ihl * 4;
    src = $urandom;
    pkt.delete();
    for (int i = 0; i < ((n > hl) ? n : hl); i++) pkt.push_back(8'($urandom_range(0, 255)));
    pkt[0] = {ver[3:0], ihl[3:0]};
    pkt[1] = 8'h00;
    pkt[2] = tl[15:8];   pkt[3] = tl[7:0];
    pkt[6] = frag[15:8]; pkt[7] = frag[7:0];
    pkt[8] = 8'd64;      pkt[9] = proto[7:0];
    pkt[10] = 8'h00;     pkt[11] = 8'h00;
    for (int i = 0; i < 4; i++) begin
      pkt[12 + i] = src[31 - 8*i -: 8];
      pkt[16 + i] = dst[31 - 8*i -: 8];
    end
    s = 0;
    for (int i = 0; i < hl; i += 2) s += {pkt[i], pkt[i+1]};
    while ((s >> 16) != 0) s = (s & 32'hFFFF) + (s >> 16);
    cs = ~s[15:0];
    pkt[10] = cs[15:8];
    pkt[11] = cs[7:0] ^ {7'd0, corrupt};
    while (pkt.size() > n) void'(pkt.pop_back());
  endtask

  // Reference model: decide the packet's fate from its bytes alone.
  task automatic model();
    int n, ihl, hl, tl, tcp, avail, cnt;
    int unsigned s;
    bit ok;
    n = pkt.size();
    ihl = int'(pkt[0][3:0]);
    hl = ihl * 4;
    exp_q.delete();
    ok = (pkt[0][7:4] == 4'd4) && (ihl >= 5) && (n > hl);
    tl = 0;
    if (ok) begin
      tl = int'({pkt[2], pkt[3]});
      ok = (pkt[9] == 8'd6) && ({pkt[16], pkt[17], pkt[18], pkt[19]} == LOCAL_IP) &&
           (({pkt[6], pkt[7]} & 16'h3FFF) == 16'h0) && (tl >= hl + 20);
      s = 0;
      for (int i = 0; i < hl; i += 2) s += {pkt[i], pkt[i+1]};
      while ((s >> 16) != 0) s = (s & 32'hFFFF) + (s >> 16);
`ifdef IPV4_HDR_CHECKSUM_EN
      ok = ok && (s == 32'hFFFF);
`endif
    end
    exp_drop = !ok;
    if (ok) begin
      tcp = tl - hl;
      avail = n - hl;
      cnt = (avail < tcp) ? avail : tcp;
      exp_err = (avail < tcp);
      exp_len = tcp;
      exp_src = {pkt[12], pkt[13], pkt[14], pkt[15]};
      exp_dst = {pkt[16], pkt[17], pkt[18], pkt[19]};
      for (int i = 0; i < cnt; i++) exp_q.push_back({(i == cnt - 1), pkt[hl + i]});
    end
  endtask

  task automatic run_pkt(input int ver, input int ihl, input int tl, input int proto,
                         input logic [31:0] dst, input logic [15:0] frag, input int n,
                         input bit corrupt, input int hold);
    build_pkt(ver, ihl, tl, proto, dst, frag, n, corrupt);
    model();
    got_q.delete();
    meta_seen = 1'b0;
    drop_cnt = 0;
    for (int i = 0; i < pkt.size(); i++) send_byte(pkt[i], (i == pkt.size() - 1));
    #2;
    if (!exp_drop) begin
      for (int k = 0; k < 20 && !meta_seen; k++) begin
        @(negedge clk);
        #2;
      end
      check("meta_valid_seen", 32'(meta_seen), 32'd1);
      check("meta_latency", first_meta_cyc, last_acc_cyc);
      for (int k = 0; k < hold; k++) begin
        @(negedge clk);
        #2;
        check("s_tready_in_meta", 32'(s_tready), 32'd0);
        check("meta_valid_held", 32'(meta_valid), 32'd1);
      end
      @(negedge clk);
      meta_ready = 1'b1;
      @(negedge clk);
      meta_ready = 1'b0;
      #2;
      check("meta_released", 32'(meta_valid), 32'd0);
      check("s_tready_after_meta", 32'(s_tready), 32'd1);
      for (int k = 0; k < 100 && m_tvalid; k++) begin
        @(negedge clk);
        #2;
      end
      check("out_count", got_q.size(), exp_q.size());
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
        check("out_byte", 32'(got_q[i]), 32'(exp_q[i]));
      check("meta_src", cap_src, exp_src);
      check("meta_dst", cap_dst, exp_dst);
      check("meta_tcp_len", 32'(cap_len), exp_len);
      check("meta_err", 32'(cap_err), 32'(exp_err));
      check("no_drop", drop_cnt, 0);
    end else begin
      repeat (3) @(negedge clk);
      #2;
      check("drop_count", drop_cnt, 1);
      check("drop_latency", drop_cyc, last_acc_cyc);
      check("drop_no_meta", 32'(meta_seen), 32'd0);
      check("drop_no_output", got_q.size(), 0);
      if (meta_valid) begin
        meta_ready = 1'b1;
        @(negedge clk);
        meta_ready = 1'b0;
      end
    end
  endtask

  initial begin
    int ver, ihl, tl, tcp, n, proto;
    logic [31:0] dst;
    logic [15:0] frag;
    bit corrupt;
    rst_n = 1'b0; meta_ready = 1'b0;
    s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    check("rst_s_tready", 32'(s_tready), 32'd0);
    check("rst_m_tvalid", 32'(m_tvalid), 32'd0);
    check("rst_m_data", 32'({m_tlast, m_tdata}), 32'd0);
    check("rst_meta_valid", 32'(meta_valid), 32'd0);
    check("rst_meta_ips", meta_src_ip | meta_dst_ip, 32'd0);
    check("rst_meta_len_err", 32'({meta_tcp_len, meta_err}), 32'd0);
    check("rst_drop", 32'(drop_pulse), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_pkt(4, 5, 40, 6, LOCAL_IP, 16'h0000, 40, 1'b0, 0);        // minimal segment
    run_pkt(4, 5, 40, 6, LOCAL_IP, 16'h0000, 46, 1'b0, 1);        // Ethernet padding
    run_pkt(4, 6, 44, 6, LOCAL_IP, 16'h0000, 44, 1'b0, 0);        // one option word
    run_pkt(4, 5, 40, 17, LOCAL_IP, 16'h0000, 40, 1'b0, 0);       // UDP
    run_pkt(4, 5, 40, 6, LOCAL_IP ^ 32'h1, 16'h0000, 40, 1'b0, 0);
    run_pkt(4, 5, 40, 6, LOCAL_IP, 16'h0000, 40, 1'b1, 0);        // bad checksum
    run_pkt(4, 5, 60, 6, LOCAL_IP, 16'h0000, 50, 1'b0, 0);        // truncated
    run_pkt(4, 5, 40, 6, LOCAL_IP, 16'h2000, 40, 1'b0, 0);        // MF
    run_pkt(4, 5, 40, 6, LOCAL_IP, 16'h0001, 40, 1'b0, 0);        // fragment offset
    run_pkt(4, 5, 40, 6, LOCAL_IP, 16'h4000, 40, 1'b0, 0);        // DF is fine
    run_pkt(4, 5, 39, 6, LOCAL_IP, 16'h0000, 45, 1'b0, 0);        // 19-byte segment
    run_pkt(4, 5, 40, 6, LOCAL_IP, 16'h0000, 12, 1'b0, 0);        // runt
    run_pkt(6, 5, 40, 6, LOCAL_IP, 16'h0000, 40, 1'b0, 0);        // wrong version
    rmode = 1;
    run_pkt(4, 7, 60, 6, LOCAL_IP, 16'h0000, 66, 1'b0, 5);        // stalls + slow meta_ready
    run_pkt(4, 5, 40, 6, LOCAL_IP, 16'h0000, 40, 1'b0, 5);
    rmode = 0;

    // Reset in the middle of a packet: no pulse, no metadata, clean restart.
    build_pkt(4, 5, 40, 6, LOCAL_IP, 16'h0000, 40, 1'b0);
    for (int i = 0; i < 10; i++) send_byte(pkt[i], 1'b0);
    rst_n = 1'b0;
    #2;
    check("midrst_s_tready", 32'(s_tready), 32'd0);
    check("midrst_meta", meta_src_ip | meta_dst_ip | 32'(meta_tcp_len), 32'd0);
    drop_cnt = 0;
    meta_seen = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    check("midrst_no_drop", drop_cnt, 0);
    check("midrst_no_meta", 32'(meta_seen), 32'd0);
    @(negedge clk);
    run_pkt(4, 5, 40, 6, LOCAL_IP, 16'h0000, 43, 1'b0, 0);

    for (int k = 0; k < 40; k++) begin
      rmode = int'($urandom_range(0, 2));
      ihl = int'($urandom_range(5, 7));
      tcp = int'($urandom_range(20, 40));
      tl = ihl * 4 + tcp;
      n = tl + int'($urandom_range(0, 6));
      ver = 4; proto = 6; dst = LOCAL_IP; corrupt = 1'b0;
      frag = ($urandom_range(0, 1) == 1) ? 16'h4000 : 16'h0000;
      case ($urandom_range(0, 11))
        0: proto = 17;
        1: dst = $urandom;
        2: frag = 16'h2000;
        3: frag = 16'($urandom_range(1, 8191));
        4: tl = ihl * 4 + int'($urandom_range(0, 19));
        5: n = ihl * 4 + int'($urandom_range(1, tcp - 1));
        6: n = int'($urandom_range(1, ihl * 4));
        7: corrupt = 1'b1;
        8: ver = 6;
        default: ;
      endcase
      run_pkt(ver, ihl, tl, proto, dst, frag, n, corrupt, int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
